// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_parity_tx_if.sv
// Byte-in / serial-out handshake between a UART client and the transmitter.
interface uart_parity_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       serial_tx;

    modport master (output tx_data, tx_start, input tx_busy, tx_done, serial_tx);
    modport slave  (input tx_data, tx_start, output tx_busy, tx_done, serial_tx);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_end marks the last clock of each CLKS_PER_BIT window.
module uart_baud_counter #(
    parameter int WIDTH        = 2,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    logic [WIDTH-1:0] count_reg;

    assign bit_end = enable && (count_reg == WIDTH'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear || bit_end) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_parity_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; registered line output.
module uart_parity_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_parity_tx_if.slave  tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_parity_tx: CLK_FREQ/BAUD must be at least 2");
    end

    tx_state_t   state_reg, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic        parity_reg, parity_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        serial_reg, serial_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        bit_end;
    logic        accept;

    uart_baud_counter #(
        .WIDTH        (CNT_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg == IDLE),
        .enable  (state_reg != IDLE),
        .bit_end (bit_end)
    );

    // A request arriving as the stop bit ends chains straight into the next start bit.
    assign accept = tx.tx_start && ((state_reg == IDLE) || (state_reg == STOP && bit_end));

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        bit_idx_next = bit_idx_reg;
        serial_next  = serial_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            START: begin
                if (bit_end) begin
                    state_next  = DATA;
                    serial_next = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                        state_next   = PARITY;
                        serial_next  = parity_reg;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        serial_next  = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next  = STOP;
                    serial_next = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next  = IDLE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    serial_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_next   = START;
            shift_next   = tx.tx_data;
            parity_next  = (^tx.tx_data) ^ (PARITY_ODD != 0);
            bit_idx_next = '0;
            serial_next  = 1'b0;
            busy_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_idx_reg <= '0;
            serial_reg  <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            bit_idx_reg <= bit_idx_next;
            serial_reg  <= serial_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign tx.serial_tx = serial_reg;
    assign tx.tx_busy   = busy_reg;
    assign tx.tx_done   = done_reg;

endmodule
